// File: rtl/debug_monitor.sv
// Debug monitor: breakpoint channels, retirement watchdog, single-step
// control and saturating cycle/retire counters. All outputs are registered.
module debug_monitor #(
    parameter int unsigned PC_W    = 16,
    parameter int unsigned NUM_BP  = 4,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PC_W-1:0]  pc,
    input  logic             pc_valid,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_idx,
    input  logic [PC_W-1:0]  cfg_addr,
    input  logic             cfg_en,
    input  logic             resume,
    input  logic             step,
    output logic             halt,
    output logic [1:0]       halt_reason,
    output logic [2:0]       hit_idx,
    output logic [PC_W-1:0]  halt_pc,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count
);

    localparam int unsigned      IDLE_W    = $clog2(TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_RUN, S_HALT, S_STEP} state_e;
    typedef enum logic [1:0] {RSN_NONE, RSN_BP, RSN_TIMEOUT, RSN_STEP} reason_e;

    state_e             state_q, state_d;
    logic               halt_q, halt_d;
    reason_e            reason_q, reason_d;
    logic [2:0]         hit_q, hit_d;
    logic [PC_W-1:0]    hpc_q, hpc_d;
    logic [CNT_W-1:0]   cycle_q, cycle_d;
    logic [CNT_W-1:0]   retire_q, retire_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic [NUM_BP-1:0]  bp_en_q, bp_en_d;
    logic [PC_W-1:0]    bp_addr_q [NUM_BP];
    logic [PC_W-1:0]    bp_addr_d [NUM_BP];

    logic               bp_hit;
    logic [2:0]         bp_idx;

    // Lowest-index enabled channel whose address equals the retiring pc
    always_comb begin
        bp_hit = 1'b0;
        bp_idx = '0;
        for (int unsigned i = 0; i < NUM_BP; i++) begin
            if (!bp_hit && bp_en_q[i] && (pc == bp_addr_q[i])) begin
                bp_hit = 1'b1;
                bp_idx = 3'(i);
            end
        end
    end

    // Next-state, capture registers, counters and breakpoint configuration
    always_comb begin
        state_d   = state_q;
        reason_d  = reason_q;
        hit_d     = hit_q;
        hpc_d     = hpc_q;
        cycle_d   = cycle_q;
        retire_d  = retire_q;
        idle_d    = idle_q;
        bp_en_d   = bp_en_q;
        bp_addr_d = bp_addr_q;

        // Matching above reads the registered config, so a same-cycle write
        // only takes effect from the next retirement.
        for (int unsigned i = 0; i < NUM_BP; i++) begin
            if (cfg_we && (cfg_idx == 3'(i))) begin
                bp_en_d[i]   = cfg_en;
                bp_addr_d[i] = cfg_addr;
            end
        end

        unique case (state_q)
            S_HALT: begin
                if (resume) begin
                    state_d = S_RUN;
                    idle_d  = '0;
                end else if (step) begin
                    state_d = S_STEP;
                    idle_d  = '0;
                end
            end
            S_RUN, S_STEP: begin
                if (cycle_q != '1) cycle_d = cycle_q + 1'b1;
                if (pc_valid) begin
                    if (retire_q != '1) retire_d = retire_q + 1'b1;
                    idle_d = '0;
                    if (state_q == S_STEP) begin
                        state_d  = S_HALT;
                        reason_d = RSN_STEP;
                        hpc_d    = pc;
                    end else if (bp_hit) begin
                        state_d  = S_HALT;
                        reason_d = RSN_BP;
                        hit_d    = bp_idx;
                        hpc_d    = pc;
                    end
                end else if (idle_q == IDLE_LAST) begin
                    state_d  = S_HALT;
                    reason_d = RSN_TIMEOUT;
                    hpc_d    = '0;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            default: state_d = S_RUN;
        endcase

        halt_d = (state_d == S_HALT);
    end

    // State register with asynchronous active-low clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_RUN;
            halt_q   <= 1'b0;
            reason_q <= RSN_NONE;
            hit_q    <= '0;
            hpc_q    <= '0;
            cycle_q  <= '0;
            retire_q <= '0;
            idle_q   <= '0;
            bp_en_q  <= '0;
            for (int unsigned i = 0; i < NUM_BP; i++) bp_addr_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            halt_q    <= halt_d;
            reason_q  <= reason_d;
            hit_q     <= hit_d;
            hpc_q     <= hpc_d;
            cycle_q   <= cycle_d;
            retire_q  <= retire_d;
            idle_q    <= idle_d;
            bp_en_q   <= bp_en_d;
            bp_addr_q <= bp_addr_d;
        end
    end

    assign halt         = halt_q;
    assign halt_reason  = reason_q;
    assign hit_idx      = hit_q;
    assign halt_pc      = hpc_q;
    assign cycle_count  = cycle_q;
    assign retire_count = retire_q;

endmodule

// File: tb/tb_debug_monitor.sv
// Bench for debug_monitor: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_debug_monitor;

    localparam int PC_W    = 16;
    localparam int NUM_BP  = 4;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 10;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [PC_W-1:0]  pc = '0;
    logic             pc_valid = 1'b0;
    logic             cfg_we = 1'b0;
    logic [2:0]       cfg_idx = '0;
    logic [PC_W-1:0]  cfg_addr = '0;
    logic             cfg_en = 1'b0;
    logic             resume = 1'b0;
    logic             step = 1'b0;
    logic             halt;
    logic [1:0]       halt_reason;
    logic [2:0]       hit_idx;
    logic [PC_W-1:0]  halt_pc;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] retire_count;

    debug_monitor #(
        .PC_W(PC_W), .NUM_BP(NUM_BP), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) u_dut (
        .clk(clk), .reset(reset), .pc(pc), .pc_valid(pc_valid),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_en(cfg_en),
        .resume(resume), .step(step), .halt(halt), .halt_reason(halt_reason),
        .hit_idx(hit_idx), .halt_pc(halt_pc), .cycle_count(cycle_count),
        .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Behavioural model: halted/stepping flags plus plain integer bookkeeping
    bit m_halted, m_stepping;
    int m_reason, m_hit, m_hpc, m_cyc, m_ret, m_idle;
    bit m_en   [NUM_BP];
    int m_addr [NUM_BP];
    int m_match, m_widx;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_halted = 0; m_stepping = 0;
            m_reason = 0; m_hit = 0; m_hpc = 0; m_cyc = 0; m_ret = 0; m_idle = 0;
            for (int i = 0; i < NUM_BP; i++) begin m_en[i] = 0; m_addr[i] = 0; end
        end else begin
            m_match = -1;
            for (int i = NUM_BP - 1; i >= 0; i--)
                if (m_en[i] && m_addr[i] == int'(pc)) m_match = i;
            if (m_halted) begin
                if (resume) begin m_halted = 0; m_stepping = 0; m_idle = 0; end
                else if (step) begin m_halted = 0; m_stepping = 1; m_idle = 0; end
            end else begin
                m_cyc = (m_cyc + 1 > CMAX) ? CMAX : m_cyc + 1;
                if (pc_valid) begin
                    m_ret  = (m_ret + 1 > CMAX) ? CMAX : m_ret + 1;
                    m_idle = 0;
                    if (m_stepping) begin
                        m_halted = 1; m_reason = 3; m_hpc = int'(pc);
                    end else if (m_match >= 0) begin
                        m_halted = 1; m_reason = 1; m_hit = m_match; m_hpc = int'(pc);
                    end
                end else if (m_idle + 1 >= TIMEOUT) begin
                    m_halted = 1; m_reason = 2; m_hpc = 0;
                end else begin
                    m_idle++;
                end
            end
            m_widx = int'(cfg_idx);
            if (cfg_we && m_widx < NUM_BP) begin
                m_en[m_widx]   = cfg_en;
                m_addr[m_widx] = int'(cfg_addr);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("halt", halt, m_halted);
            chk("halt_reason", halt_reason, m_reason);
            chk("hit_idx", hit_idx, m_hit);
            chk("halt_pc", halt_pc, m_hpc);
            chk("cycle_count", cycle_count, m_cyc);
            chk("retire_count", retire_count, m_ret);
        end
    end

    task automatic cyc(input bit pv, input int p, input bit we, input int idx,
                       input int addr, input bit en, input bit r, input bit s);
        pc_valid = pv; pc = PC_W'(p);
        cfg_we = we; cfg_idx = 3'(idx); cfg_addr = PC_W'(addr); cfg_en = en;
        resume = r; step = s;
        @(negedge clk); #1;
        pc_valid = 1'b0; cfg_we = 1'b0; resume = 1'b0; step = 1'b0;
    endtask

    task automatic run_pc(input int p);   cyc(1, p, 0, 0, 0, 0, 0, 0); endtask
    task automatic idle(input int n);     repeat (n) cyc(0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic cfg(input int idx, input int addr, input bit en);
        cyc(0, 0, 1, idx, addr, en, 0, 0);
    endtask
    task automatic ctl(input bit r, input bit s); cyc(0, 0, 0, 0, 0, 0, r, s); endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk); #1;
        @(negedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int rate;
    int thr [4] = '{0, 1, 4, 7};
    bit pv;

    initial begin
        do_reset();
        cmp_en = 1'b1;
        chk("reset halt", halt, 0);
        chk("reset cycle_count", cycle_count, 0);

        // bp0 at 7, retire 0..7
        cfg(0, 7, 1);
        for (int p = 0; p < 7; p++) run_pc(p);
        chk("bp0 pre halt", halt, 0);
        run_pc(7);
        chk("bp0 halt", halt, 1);
        chk("bp0 reason", halt_reason, 1);
        chk("bp0 hit_idx", hit_idx, 0);
        chk("bp0 halt_pc", halt_pc, 7);
        chk("bp0 retire", retire_count, 8);
        chk("bp0 cycles", cycle_count, 9);

        // two channels on 5, lowest index wins; resume keeps reason
        cfg(1, 5, 1);
        cfg(3, 5, 1);
        ctl(1, 0);
        chk("resume halt", halt, 0);
        chk("resume reason", halt_reason, 1);
        run_pc(5);
        chk("bp1 halt", halt, 1);
        chk("bp1 hit_idx", hit_idx, 1);
        chk("bp1 halt_pc", halt_pc, 5);
        chk("bp1 retire", retire_count, 9);
        ctl(1, 0);
        chk("resume2 halt", halt, 0);
        chk("resume2 hit_idx", hit_idx, 1);

        // single step; breakpoint at 8 ignored while stepping
        cfg(2, 8, 1);
        run_pc(5);
        chk("bp1b halt", halt, 1);
        ctl(0, 1);
        chk("step halt", halt, 0);
        idle(1);
        run_pc(8);
        chk("step done halt", halt, 1);
        chk("step reason", halt_reason, 3);
        chk("step halt_pc", halt_pc, 8);
        chk("step hit_idx", hit_idx, 1);
        chk("step retire", retire_count, 11);
        run_pc(8);
        chk("halted retire ignored", retire_count, 11);

        // resume beats step; step outside halt ignored; saturation
        ctl(1, 1);
        chk("res+step halt", halt, 0);
        run_pc(100);
        chk("res+step is run", halt, 0);
        ctl(0, 1);
        run_pc(101);
        chk("step in run ignored", halt, 0);
        repeat (20) run_pc(200);
        chk("cycle sat", cycle_count, 15);
        chk("retire sat", retire_count, 15);

        // same-cycle write uses old value; out-of-range index; disabled channel
        cyc(1, 20, 1, 0, 20, 1, 0, 0);
        chk("wr+match old", halt, 0);
        run_pc(20);
        chk("new bp0 halt", halt, 1);
        chk("new bp0 halt_pc", halt_pc, 20);
        ctl(1, 0);
        cfg(5, 30, 1);
        run_pc(30);
        chk("idx5 ignored", halt, 0);
        cfg(1, 40, 0);
        run_pc(40);
        chk("disabled bp", halt, 0);

        // watchdog from reset, then in step
        do_reset();
        idle(9);
        chk("wd pre halt", halt, 0);
        idle(1);
        chk("wd halt", halt, 1);
        chk("wd reason", halt_reason, 2);
        chk("wd halt_pc", halt_pc, 0);
        chk("wd cycles", cycle_count, 10);
        ctl(0, 1);
        idle(9);
        chk("step wd pre", halt, 0);
        idle(1);
        chk("step wd halt", halt, 1);
        chk("step wd reason", halt_reason, 2);

        // asynchronous reset while halted
        do_reset();
        cfg(0, 7, 1);
        run_pc(7);
        chk("pre-rst halt", halt, 1);
        reset = 1'b0;
        #1;
        chk("async halt", halt, 0);
        chk("async reason", halt_reason, 0);
        chk("async halt_pc", halt_pc, 0);
        chk("async retire", retire_count, 0);
        @(negedge clk); #1;
        reset = 1'b1;
        run_pc(7);
        chk("bp cleared", halt, 0);
        chk("post-rst retire", retire_count, 1);

        // randomized traffic
        rate = 2;
        for (int n = 0; n < 1500; n++) begin
            if (n % 50 == 0) rate = int'($urandom_range(0, 3));
            pv = (int'($urandom_range(0, 7)) < thr[rate]);
            cyc(pv, int'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b0;
                idle(1);
                reset = 1'b1;
            end
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
